// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: h/v counters, sync/active decode and pixel coordinates.
// Config is written to shadow registers and copied into the live set at frame end or on OP_RESET.
module video_timing_gen #(
    parameter int H_W = 12,
    parameter int V_W = 12
) (
    input  logic           dvi_clk,
    input  logic           reset,
    input  logic [7:0]     control_op,
    input  logic [31:0]    control_data,
    output logic           dvi_hsync,
    output logic           dvi_vsync,
    output logic           dvi_active_video,
    output logic [H_W-1:0] pix_x,
    output logic [V_W-1:0] pix_y,
    output logic           frame_start
);

    typedef struct packed {
        logic [H_W-1:0] h_total;
        logic [H_W-1:0] h_active;
        logic [H_W-1:0] hs_start;
        logic [H_W-1:0] hs_end;
        logic [V_W-1:0] v_total;
        logic [V_W-1:0] v_active;
        logic [V_W-1:0] vs_start;
        logic [V_W-1:0] vs_end;
        logic           hs_pol;
        logic           vs_pol;
        logic           vdouble;
        logic           enable;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        h_total:  H_W'(800), h_active: H_W'(640), hs_start: H_W'(656), hs_end: H_W'(752),
        v_total:  V_W'(525), v_active: V_W'(480), vs_start: V_W'(490), vs_end: V_W'(492),
        hs_pol: 1'b0, vs_pol: 1'b0, vdouble: 1'b0, enable: 1'b1
    };

    localparam logic [7:0] OP_HTIME  = 8'd1;
    localparam logic [7:0] OP_HSYNC  = 8'd2;
    localparam logic [7:0] OP_VTIME  = 8'd3;
    localparam logic [7:0] OP_VSYNC  = 8'd4;
    localparam logic [7:0] OP_MODE   = 8'd5;
    localparam logic [7:0] OP_RESET  = 8'd11;

    cfg_t           shadow;
    cfg_t           live;
    logic [H_W-1:0] h_p0;
    logic [V_W-1:0] v_p0;
    logic           h_last;
    logic           v_last;
    logic           frame_end;
    logic           reload;
    logic           hs_in;
    logic           vs_in;

    assign reload    = (control_op == OP_RESET) && control_data[0];
    // A total of 0 or 1 pins the counter at 0, so every cycle counts as its last position.
    assign h_last    = (live.h_total <= H_W'(1)) || (h_p0 == live.h_total - H_W'(1));
    assign v_last    = (live.v_total <= V_W'(1)) || (v_p0 == live.v_total - V_W'(1));
    assign frame_end = live.enable && h_last && v_last;
    assign hs_in     = (h_p0 >= live.hs_start) && (h_p0 < live.hs_end);
    assign vs_in     = (v_p0 >= live.vs_start) && (v_p0 < live.vs_end);

    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            shadow <= CFG_DEFAULT;
        end else begin
            case (control_op)
                OP_HTIME: begin
                    shadow.h_total  <= control_data[16 +: H_W];
                    shadow.h_active <= control_data[0 +: H_W];
                end
                OP_HSYNC: begin
                    shadow.hs_end   <= control_data[16 +: H_W];
                    shadow.hs_start <= control_data[0 +: H_W];
                end
                OP_VTIME: begin
                    shadow.v_total  <= control_data[16 +: V_W];
                    shadow.v_active <= control_data[0 +: V_W];
                end
                OP_VSYNC: begin
                    shadow.vs_end   <= control_data[16 +: V_W];
                    shadow.vs_start <= control_data[0 +: V_W];
                end
                OP_MODE: begin
                    {shadow.enable, shadow.vdouble, shadow.vs_pol, shadow.hs_pol} <= control_data[3:0];
                end
                default: ;
            endcase
        end
    end

    // Live config only changes at a frame boundary or on an explicit reload.
    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            live <= CFG_DEFAULT;
        end else if (reload || frame_end) begin
            live <= shadow;
        end
    end

    // Stage p0: raster counters
    always_ff @(posedge dvi_clk) begin
        if (reset || reload || !live.enable) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (h_last) begin
            h_p0 <= '0;
            v_p0 <= v_last ? '0 : v_p0 + V_W'(1);
        end else begin
            h_p0 <= h_p0 + H_W'(1);
        end
    end

    // Stage p1: registered decode of the counter state
    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            dvi_hsync        <= ~CFG_DEFAULT.hs_pol;
            dvi_vsync        <= ~CFG_DEFAULT.vs_pol;
            dvi_active_video <= 1'b0;
            pix_x            <= '0;
            pix_y            <= '0;
            frame_start      <= 1'b0;
        end else if (!live.enable) begin
            dvi_hsync        <= ~live.hs_pol;
            dvi_vsync        <= ~live.vs_pol;
            dvi_active_video <= 1'b0;
            pix_x            <= '0;
            pix_y            <= '0;
            frame_start      <= 1'b0;
        end else begin
            dvi_hsync        <= hs_in ? live.hs_pol : ~live.hs_pol;
            dvi_vsync        <= vs_in ? live.vs_pol : ~live.vs_pol;
            dvi_active_video <= (h_p0 < live.h_active) && (v_p0 < live.v_active);
            pix_x            <= h_p0;
            pix_y            <= live.vdouble ? (v_p0 >> 1) : v_p0;
            frame_start      <= (h_p0 == '0) && (v_p0 == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 line timing, a tiny programmed raster,
// frame-synchronous updates, polarity/line-doubling, enable and mid-frame reset.
module tb_video_timing_gen;

    logic        dvi_clk;
    logic        reset;
    logic [7:0]  control_op;
    logic [31:0] control_data;
    logic        dvi_hsync;
    logic        dvi_vsync;
    logic        dvi_active_video;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;

    int vectors;
    int miscompares;

    video_timing_gen #(.H_W(12), .V_W(12)) dut (
        .dvi_clk(dvi_clk),
        .reset(reset),
        .control_op(control_op),
        .control_data(control_data),
        .dvi_hsync(dvi_hsync),
        .dvi_vsync(dvi_vsync),
        .dvi_active_video(dvi_active_video),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .frame_start(frame_start)
    );

    initial dvi_clk = 1'b0;
    always #5 dvi_clk = ~dvi_clk;

    task automatic tick();
        @(posedge dvi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_tuple();
        return {4'b0, dvi_hsync, dvi_vsync, dvi_active_video, frame_start, pix_x, pix_y};
    endfunction

    function automatic logic [31:0] exp_tuple(input logic hs, input logic vs, input logic act,
                                              input logic fs, input int x, input int y);
        return {4'b0, hs, vs, act, fs, 12'(x), 12'(y)};
    endfunction

    task automatic op(input logic [7:0] code, input logic [31:0] data);
        control_op   = code;
        control_data = data;
        tick();
        control_op   = 8'd0;
        control_data = 32'd0;
    endtask

    // Default 640x480 timing over the first two lines; sample k=0 is the frame_start output.
    task automatic measure_640(input string tag);
        int   first_fall;
        int   second_fall;
        int   lows;
        int   acts;
        int   vlows;
        logic prev;
        first_fall = -1; second_fall = -1; lows = 0; acts = 0; vlows = 0; prev = 1'b1;
        for (int k = 0; k < 1600; k++) begin
            tick();
            if (k == 0)   chk({tag, " first pixel"}, obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b1, 1'b1, 0, 0));
            if (k == 1)   chk({tag, " second pixel"}, obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b1, 1'b0, 1, 0));
            if (k == 799) chk({tag, " line end x"}, 32'(pix_x), 32'd799);
            if (k == 800) chk({tag, " line1 start"}, obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b1, 1'b0, 0, 1));
            if (prev && !dvi_hsync) begin
                if (first_fall < 0) first_fall = k;
                else if (second_fall < 0) second_fall = k;
            end
            prev = dvi_hsync;
            if (k < 800) begin
                lows += int'(!dvi_hsync);
                acts += int'(dvi_active_video);
            end
            vlows += int'(!dvi_vsync);
        end
        chk({tag, " hsync first fall"}, 32'(first_fall), 32'd656);
        chk({tag, " hsync period"}, 32'(second_fall - first_fall), 32'd800);
        chk({tag, " hsync low width"}, 32'(lows), 32'd96);
        chk({tag, " active per line"}, 32'(acts), 32'd640);
        chk({tag, " vsync low lines0-1"}, 32'(vlows), 32'd0);
    endtask

    // Tiny raster: 10 cycles/line, 4 lines, 6 active pixels on lines 0-1, vsync on line 3.
    task automatic run_tiny(input string tag, input int k0, input int k1, input int hs_s, input int hs_e,
                            input logic hpol, input logic vpol, input logic vdbl);
        int   h;
        int   v;
        logic hs;
        logic vs;
        for (int k = k0; k < k1; k++) begin
            tick();
            h  = k % 10;
            v  = (k / 10) % 4;
            hs = (h >= hs_s && h < hs_e) ? hpol : ~hpol;
            vs = (v == 3) ? vpol : ~vpol;
            chk($sformatf("%s k=%0d", tag, k), obs_tuple(),
                exp_tuple(hs, vs, (h < 6) && (v < 2), (h == 0) && (v == 0), h, vdbl ? v / 2 : v));
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        control_op   = 8'd0;
        control_data = 32'd0;
        tick();
        tick();
        chk("reset outputs", obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        tick();
        chk("reset held", obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b0, 1'b0, 0, 0));

        reset = 1'b0;
        measure_640("default");

        op(8'd1, {16'd10, 16'd6});
        op(8'd2, {16'd9, 16'd7});
        op(8'd3, {16'd4, 16'd2});
        op(8'd4, {16'd4, 16'd3});
        op(8'd11, 32'd1);
        run_tiny("tiny", 0, 85, 7, 9, 1'b0, 1'b0, 1'b0);

        // hsync rewrite mid-frame: old window until the frame wraps at k=120
        control_op   = 8'd2;
        control_data = {16'd4, 16'd2};
        run_tiny("midframe", 85, 86, 7, 9, 1'b0, 1'b0, 1'b0);
        control_op   = 8'd0;
        control_data = 32'd0;
        run_tiny("old hs", 86, 120, 7, 9, 1'b0, 1'b0, 1'b0);
        run_tiny("new hs", 120, 160, 2, 4, 1'b0, 1'b0, 1'b0);

        op(8'd5, 32'hF);
        op(8'd11, 32'd1);
        run_tiny("pol vdouble", 0, 40, 2, 4, 1'b1, 1'b1, 1'b1);

        op(8'd5, 32'h0);
        op(8'd11, 32'd1);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("disabled k=%0d", k), obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        end
        op(8'd11, 32'd0);
        tick();
        chk("reset op data0=0", obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        op(8'd5, 32'h8);
        op(8'd11, 32'd1);
        run_tiny("reenable", 0, 24, 2, 4, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        tick();
        chk("midline reset", obs_tuple(), exp_tuple(1'b1, 1'b1, 1'b0, 1'b0, 0, 0));
        reset = 1'b0;
        measure_640("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
